// File: rtl/popcount_arbiter_pkg.sv
// Shared constants and state encoding for the popcount arbiter slice.
package popcount_pkg;

  localparam int DATA_W = 7;   // requester word width
  localparam int CNT_W  = 3;   // popcount result width
  localparam int SEL_W  = 2;   // mux-check select width
  localparam int N_REQ  = 4;   // number of requesters
  localparam int ID_W   = 2;   // requester index width

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/popcount_arbiter_if.sv
// Request/result bus between the requesters, the consumer and the arbiter.
interface popcount_arbiter_if #(
  parameter int STAT_W = 8
);
  import popcount_pkg::*;

  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic [N_REQ*SEL_W-1:0]   req_sel;
  logic [N_REQ-1:0]         gnt;
  logic                     res_valid;
  logic                     res_ready;
  logic [ID_W-1:0]          res_id;
  logic [CNT_W-1:0]         res_count;
  logic                     res_match;
  logic [STAT_W-1:0]        match_cnt;

  // Requesters and consumer side
  modport master (
    output req, req_data, req_sel, res_ready,
    input  gnt, res_valid, res_id, res_count, res_match, match_cnt
  );

  // Arbiter side
  modport slave (
    input  req, req_data, req_sel, res_ready,
    output gnt, res_valid, res_id, res_count, res_match, match_cnt
  );

endinterface

// File: rtl/popcount_arbiter_enc.sv
// Existing encoder: number of set bits in a 7-bit word.
module popcount_enc
  import popcount_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  output logic [CNT_W-1:0]  y
);

  // Sum the individual bits of the word.
  always_comb begin
    y = '0;
    for (int i = 0; i < DATA_W; i++) begin
      y = y + CNT_W'(x[i]);
    end
  end

endmodule

// File: rtl/popcount_arbiter_mux.sv
// Existing mux check: z is high when the number of set bits in y equals s.
module mux_check
  import popcount_pkg::*;
(
  input  logic [CNT_W-1:0] y,
  input  logic [SEL_W-1:0] s,
  output logic             z
);

  logic [SEL_W-1:0] ones;

  // A 3-bit y has at most three set bits, so the sum fits the select width.
  always_comb begin
    ones = {1'b0, y[0]} + {1'b0, y[1]} + {1'b0, y[2]};
    z    = (ones == s);
  end

endmodule

// File: rtl/popcount_arbiter_rr.sv
// Combinational round-robin winner select: first asserted request at or
// after ptr, wrapping around. Shared with other shared-resource blocks.
module rr_arbiter
  import popcount_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    winner = ptr;
    any    = 1'b0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin scheduler sharing one popcount + mux-check datapath between
// four requesters. One result register stage with a valid/ready handshake
// and a saturating count of consumed matching results.
module popcount_arbiter
  import popcount_pkg::*;
#(
  parameter int N_REQ_P = 4,
  parameter int STAT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  popcount_arbiter_if.slave   bus
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     winner;
  logic                any;
  logic                accept;
  logic                consume;
  logic [DATA_W-1:0]   word_p0;
  logic [SEL_W-1:0]    sel_p0;
  logic [CNT_W-1:0]    cnt_p0;
  logic                match_p0;

  logic                vld_p1;
  logic [ID_W-1:0]     id_p1;
  logic [CNT_W-1:0]    cnt_p1;
  logic                match_p1;
  logic [STAT_W-1:0]   stat_cnt;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

  // Stage p0: arbitrate, mux the winner's operands, run the shared datapath
  rr_arbiter u_rr (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign accept  = any && ((state == IDLE) || bus.res_ready) && !rst;
  assign consume = (state == FULL) && bus.res_ready;
  assign bus.gnt = accept ? (N_REQ'(1) << winner) : '0;

  // Select the winning requester's word and select fields.
  always_comb begin
    word_p0 = bus.req_data[DATA_W*int'(winner) +: DATA_W];
    sel_p0  = bus.req_sel[SEL_W*int'(winner) +: SEL_W];
  end

  popcount_enc u_enc (
    .x (word_p0),
    .y (cnt_p0)
  );

  mux_check u_mux (
    .y (cnt_p0),
    .s (sel_p0),
    .z (match_p0)
  );

  // Stage p1: result registers, state, pointer and match statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vld_p1   <= 1'b0;
      id_p1    <= '0;
      cnt_p1   <= '0;
      match_p1 <= 1'b0;
      ptr      <= '0;
      stat_cnt <= '0;
    end else begin
      if (consume && match_p1) begin
        stat_cnt <= sat_inc(stat_cnt);
      end
      if (accept) begin
        state    <= FULL;
        vld_p1   <= 1'b1;
        id_p1    <= winner;
        cnt_p1   <= cnt_p0;
        match_p1 <= match_p0;
        ptr      <= winner + ID_W'(1);
      end else if (consume) begin
        state  <= IDLE;
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.res_valid = vld_p1;
  assign bus.res_id    = id_p1;
  assign bus.res_count = cnt_p1;
  assign bus.res_match = match_p1;
  assign bus.match_cnt = stat_cnt;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter: handshake, round-robin order,
// back-pressure, match logic, counter saturation and mid-transaction reset.
module tb_popcount_arbiter;
  import popcount_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  popcount_arbiter_if #(.STAT_W(8)) bus ();

  popcount_arbiter #(.N_REQ_P(4), .STAT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [1:0] id,
                         input logic [2:0] cnt, input logic m);
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
    chk({tag, ".id"},    32'(bus.res_id),    32'(id));
    chk({tag, ".count"}, 32'(bus.res_count), 32'(cnt));
    chk({tag, ".match"}, 32'(bus.res_match), 32'(m));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_sel = '0;
    bus.res_ready = 1'b0;

    // Reset state, with a pending request that must stay ungranted
    bus.req = 4'b1000;
    @(negedge clk);
    #1 chk("rst.gnt", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    chk_res("rst", 1'b0, 2'd0, 3'd0, 1'b0);
    chk("rst.match_cnt", 32'(bus.match_cnt), 32'h0);
    bus.req = '0;
    rst = 1'b0;

    // First transaction: all-ones word, sel 3 -> count 7, y=111 has 3 ones
    @(negedge clk);
    bus.req = 4'b0001;
    bus.req_data = {7'd0, 7'd0, 7'd0, 7'b1111111};
    bus.req_sel = {2'd0, 2'd0, 2'd0, 2'b11};
    bus.res_ready = 1'b1;
    #1 chk("t1.gnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req = '0;
    chk_res("t1", 1'b1, 2'd0, 3'd7, 1'b1);
    chk("t1.cnt_before", 32'(bus.match_cnt), 32'd0);
    @(negedge clk);
    chk("t1.cnt_after", 32'(bus.match_cnt), 32'd1);
    chk("t1.idle", 32'(bus.res_valid), 32'd0);

    // Single requester 3 wins even though ptr points at 1; ptr then wraps to 0
    bus.req = 4'b1000;
    bus.req_data = {7'b0001111, 7'b0000111, 7'b0000011, 7'b0000001};
    bus.req_sel = 8'h00;
    #1 chk("single.gnt", 32'(bus.gnt), 32'b1000);
    @(negedge clk);
    chk_res("single", 1'b1, 2'd3, 3'd4, 1'b0);

    // All four held with ready high: 0,1,2,3,0,1,2,3 back to back
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("rr%0d.gnt", k), 32'(bus.gnt), 32'(4'b0001 << (k % 4)));
      @(negedge clk);
      chk_res($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 3'(k % 4 + 1), 1'b0);
    end
    bus.req = '0;
    @(negedge clk);
    chk("rr.idle", 32'(bus.res_valid), 32'd0);
    chk("rr.match_cnt", 32'(bus.match_cnt), 32'd1);

    // Back-pressure: result held while ready low, second request blocked
    bus.res_ready = 1'b0;
    bus.req = 4'b0100;
    bus.req_data = {7'd0, 7'b0001111, 7'b0000011, 7'd0};
    bus.req_sel = {2'd0, 2'b01, 2'b01, 2'd0};
    #1 chk("bp.gnt2", 32'(bus.gnt), 32'b0100);
    @(negedge clk);
    bus.req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      chk_res($sformatf("bp_hold%0d", k), 1'b1, 2'd2, 3'd4, 1'b1);
      #1 chk($sformatf("bp_hold%0d.gnt", k), 32'(bus.gnt), 32'h0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    #1 chk("bp.gnt1", 32'(bus.gnt), 32'b0010);
    @(negedge clk);
    bus.req = '0;
    chk_res("bp_new", 1'b1, 2'd1, 3'd2, 1'b1);
    chk("bp.cnt2", 32'(bus.match_cnt), 32'd2);
    @(negedge clk);
    chk("bp.cnt3", 32'(bus.match_cnt), 32'd3);
    chk("bp.idle", 32'(bus.res_valid), 32'd0);

    // Non-match (y=100, sel 2) then zero word with sel 0 (match)
    bus.req = 4'b0001;
    bus.req_data = {7'd0, 7'd0, 7'd0, 7'b0001111};
    bus.req_sel = {2'd0, 2'd0, 2'd0, 2'b10};
    #1 chk("nm.gnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req_data = '0;
    bus.req_sel = '0;
    chk_res("nm", 1'b1, 2'd0, 3'd4, 1'b0);
    #1 chk("zero.gnt", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req = '0;
    chk_res("zero", 1'b1, 2'd0, 3'd0, 1'b1);
    chk("nm.cnt", 32'(bus.match_cnt), 32'd3);
    @(negedge clk);
    chk("zero.cnt", 32'(bus.match_cnt), 32'd4);

    // Saturation: 251 more matches reach 255, then one extra stays at 255
    bus.req = 4'b0001;
    bus.req_data = {7'd0, 7'd0, 7'd0, 7'b1111111};
    bus.req_sel = {2'd0, 2'd0, 2'd0, 2'b11};
    repeat (251) @(negedge clk);
    bus.req = '0;
    chk("sat.254", 32'(bus.match_cnt), 32'd254);
    @(negedge clk);
    chk("sat.255", 32'(bus.match_cnt), 32'd255);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    chk("sat.valid", 32'(bus.res_valid), 32'd1);
    @(negedge clk);
    chk("sat.hold", 32'(bus.match_cnt), 32'hFF);

    // Reset mid-FULL with ptr at 2 and requester 3 pending
    bus.res_ready = 1'b0;
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = 4'b1000;
    chk("mid.full", 32'(bus.res_valid), 32'd1);
    #1 chk("mid.gnt_blocked", 32'(bus.gnt), 32'h0);
    #1 rst = 1'b1;
    #1 chk("mid.valid_async", 32'(bus.res_valid), 32'd0);
    chk("mid.gnt_rst", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    chk("mid.gnt_rst2", 32'(bus.gnt), 32'h0);
    chk("mid.cnt_rst", 32'(bus.match_cnt), 32'h0);
    rst = 1'b0;
    bus.req = 4'b1001;
    #1 chk("mid.gnt_ptr0", 32'(bus.gnt), 32'b0001);
    @(negedge clk);
    bus.req = '0;
    chk("mid.res_id", 32'(bus.res_id), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
